// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter.
// Optional start timeout is enabled with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                           SysClk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]             Ack,
  output logic [NUM_REQ-1:0]             Done,
  output logic [$clog2(NUM_REQ)-1:0]     Grant_Id,
  output logic                           Arb_Busy,
  output logic [DATA_BITS-1:0]           Tx_Data,
  output logic                           Transmit_Start,
  input  logic                           Tx_Busy,
  output logic                           Timeout_Err
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       last, last_nxt;
  logic [IDW-1:0]       gid_nxt, win, idx;
  logic                 found;
  logic [NUM_REQ-1:0]   ack_nxt, done_nxt;
  logic [DATA_BITS-1:0] txd_nxt;
  logic                 start_nxt;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(START_TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tmo_nxt;
`endif

  // Round-robin search: nearest requester after the last one served wins
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = IDW'((int'(last) + off) % NUM_REQ);
      if (Req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gid_nxt   = Grant_Id;
    txd_nxt   = Tx_Data;
    start_nxt = Transmit_Start;
    ack_nxt   = '0;
    done_nxt  = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_nxt   = cnt;
    tmo_nxt   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found && !Tx_Busy) begin
          txd_nxt      = Req_Data[int'(win)*DATA_BITS +: DATA_BITS];
          gid_nxt      = win;
          ack_nxt[win] = 1'b1;
          start_nxt    = 1'b1;
          state_nxt    = START;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_nxt      = '0;
`endif
        end
      end
      START: begin
        if (Tx_Busy) begin
          start_nxt = 1'b0;
          state_nxt = WAIT_DONE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt == CW'(START_TIMEOUT - 1)) begin
          start_nxt          = 1'b0;
          tmo_nxt            = 1'b1;
          done_nxt[Grant_Id] = 1'b1;
          last_nxt           = Grant_Id;
          state_nxt          = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!Tx_Busy) begin
          done_nxt[Grant_Id] = 1'b1;
          last_nxt           = Grant_Id;
          state_nxt          = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer and output registers
  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      state          <= IDLE;
      last           <= IDW'(NUM_REQ - 1);
      Grant_Id       <= '0;
      Tx_Data        <= '0;
      Transmit_Start <= 1'b0;
      Ack            <= '0;
      Done           <= '0;
      Arb_Busy       <= 1'b0;
    end else begin
      state          <= state_nxt;
      last           <= last_nxt;
      Grant_Id       <= gid_nxt;
      Tx_Data        <= txd_nxt;
      Transmit_Start <= start_nxt;
      Ack            <= ack_nxt;
      Done           <= done_nxt;
      Arb_Busy       <= (state_nxt != IDLE);
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Start-handshake watchdog counter and error pulse
  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      cnt         <= '0;
      Timeout_Err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      Timeout_Err <= tmo_nxt;
    end
  end
`else
  assign Timeout_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner cases and
// randomized traffic against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;

  logic          SysClk = 1'b0;
  logic          Rst = 1'b1;
  logic [N-1:0]  Req = '0;
  logic [N*DB-1:0] Req_Data = '0;
  logic          Tx_Busy = 1'b0;
  logic [N-1:0]  Ack, Done;
  logic [1:0]    Grant_Id;
  logic          Arb_Busy, Transmit_Start, Timeout_Err;
  logic [DB-1:0] Tx_Data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 SysClk = ~SysClk;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_BITS(DB), .START_TIMEOUT(16)
  ) dut (
    .SysClk(SysClk), .Rst(Rst), .Req(Req), .Req_Data(Req_Data),
    .Ack(Ack), .Done(Done), .Grant_Id(Grant_Id), .Arb_Busy(Arb_Busy),
    .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start),
    .Tx_Busy(Tx_Busy), .Timeout_Err(Timeout_Err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++)
      if (r[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  task automatic do_reset();
    Rst = 1'b1;
    Req = '0;
    Tx_Busy = 1'b0;
    @(negedge SysClk);
    Rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       busy;
    logic [3:0] ack;
    logic [3:0] done;
    logic       start;
    logic [1:0] gid;
    logic       abusy;
    logic [7:0] txd;
  } vec_t;

  vec_t tbl[19];

  // random-phase model and stimulus state
  logic [N-1:0]    r, ea, ed;
  logic            b;
  logic [N*DB-1:0] d;
  int              m_owner, m_last, m_gid, w;
  bit              m_started;
  logic [7:0]      m_txd;
  int              u_phase, u_cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        rst   req      busy  ack      done     st    gid    ab    txd
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1, 8'h10};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1, 8'h10};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h10};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h10};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 8'h10};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1, 8'h11};
    tbl[8]  = '{1'b0, 4'b1101, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1, 8'h11};
    tbl[9]  = '{1'b0, 4'b1101, 1'b0, 4'b0000, 4'b0010, 1'b0, 2'd1, 1'b0, 8'h11};
    tbl[10] = '{1'b0, 4'b1101, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1, 8'h12};
    tbl[11] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, 8'h12};
    tbl[12] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b0, 8'h12};
    tbl[13] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b1, 8'h13};
    tbl[14] = '{1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1, 8'h13};
    tbl[15] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd3, 1'b0, 8'h13};
    tbl[16] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1, 8'h10};
    tbl[17] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[18] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1, 8'h10};

    Req_Data = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge SysClk);
    for (int i = 0; i < 19; i++) begin
      Rst = tbl[i].rst;
      Req = tbl[i].req;
      Tx_Busy = tbl[i].busy;
      @(negedge SysClk);
      chk($sformatf("tbl%0d.ack", i), Ack, tbl[i].ack);
      chk($sformatf("tbl%0d.done", i), Done, tbl[i].done);
      chk($sformatf("tbl%0d.start", i), Transmit_Start, tbl[i].start);
      chk($sformatf("tbl%0d.gid", i), Grant_Id, tbl[i].gid);
      chk($sformatf("tbl%0d.abusy", i), Arb_Busy, tbl[i].abusy);
      chk($sformatf("tbl%0d.txd", i), Tx_Data, tbl[i].txd);
      chk($sformatf("tbl%0d.tmo", i), Timeout_Err, 1'b0);
    end

    // reset while in START drops Transmit_Start at once
    do_reset();
    Req = 4'b0010;
    @(negedge SysClk);
    chk("rstS.ack", Ack, 4'b0010);
    chk("rstS.start", Transmit_Start, 1'b1);
    #2 Rst = 1'b1;
    #1;
    chk("rstS.start_async", Transmit_Start, 1'b0);
    chk("rstS.abusy_async", Arb_Busy, 1'b0);
    @(negedge SysClk);
    Rst = 1'b0;

    // reset during WAIT_DONE for requester 1: no Done, pointer restarts
    Req = 4'b0010;
    @(negedge SysClk);
    chk("rstW.ack", Ack, 4'b0010);
    Req = 4'b0000;
    Tx_Busy = 1'b1;
    @(negedge SysClk);
    chk("rstW.wait_abusy", Arb_Busy, 1'b1);
    chk("rstW.wait_start", Transmit_Start, 1'b0);
    #2 Rst = 1'b1;
    #1;
    chk("rstW.abusy_async", Arb_Busy, 1'b0);
    @(negedge SysClk);
    Rst = 1'b0;
    Tx_Busy = 1'b0;
    Req = 4'b0011;
    @(negedge SysClk);
    chk("rstW.no_done", Done, 4'b0000);
    chk("rstW.regrant", Ack, 4'b0001);
    chk("rstW.gid", Grant_Id, 2'd0);

    // data changed after Ack does not affect latched byte
    do_reset();
    Req_Data[31:24] = 8'h3C;
    Req = 4'b1000;
    @(negedge SysClk);
    chk("hold.ack", Ack, 4'b1000);
    chk("hold.txd0", Tx_Data, 8'h3C);
    Req_Data[31:24] = 8'hFF;
    @(negedge SysClk);
    chk("hold.txd1", Tx_Data, 8'h3C);
    Tx_Busy = 1'b1;
    @(negedge SysClk);
    chk("hold.txd2", Tx_Data, 8'h3C);
    Tx_Busy = 1'b0;
    Req = 4'b0000;
    @(negedge SysClk);
    chk("hold.done", Done, 4'b1000);
    chk("hold.txd3", Tx_Data, 8'h3C);

    // request while UART is busy from an earlier frame
    do_reset();
    Tx_Busy = 1'b1;
    Req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge SysClk);
      chk($sformatf("busy.noack%0d", k), Ack, 4'b0000);
    end
    Tx_Busy = 1'b0;
    @(negedge SysClk);
    chk("busy.ack", Ack, 4'b0100);
    chk("busy.gid", Grant_Id, 2'd2);

`ifdef UART_TX_ARB_TIMEOUT_EN
    do_reset();
    Req = 4'b0001;
    @(negedge SysClk);
    chk("tmo.ack", Ack, 4'b0001);
    Req = 4'b0000;
    for (int k = 1; k < 16; k++) begin
      @(negedge SysClk);
      chk($sformatf("tmo.quiet%0d", k), Timeout_Err, 1'b0);
      chk($sformatf("tmo.start%0d", k), Transmit_Start, 1'b1);
    end
    @(negedge SysClk);
    chk("tmo.err", Timeout_Err, 1'b1);
    chk("tmo.done", Done, 4'b0001);
    chk("tmo.start", Transmit_Start, 1'b0);
    chk("tmo.abusy", Arb_Busy, 1'b0);
`endif

    // randomized traffic against the transaction-level model
    do_reset();
    m_owner = -1;
    m_last = N - 1;
    m_gid = 0;
    m_started = 0;
    m_txd = '0;
    u_phase = 0;
    u_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge SysClk);
      r = Req;
      b = Tx_Busy;
      d = Req_Data;
      ea = '0;
      ed = '0;
      if (m_owner < 0) begin
        if (|r && !b) begin
          w = rr(r, m_last);
          ea[w] = 1'b1;
          m_owner = w;
          m_gid = w;
          m_started = 0;
          m_txd = d[w*DB +: DB];
        end
      end else if (!m_started) begin
        if (b) m_started = 1;
      end else if (!b) begin
        ed[m_owner] = 1'b1;
        m_last = m_owner;
        m_owner = -1;
      end
      chk($sformatf("rnd%0d.ack", c), Ack, ea);
      chk($sformatf("rnd%0d.done", c), Done, ed);
      chk($sformatf("rnd%0d.start", c), Transmit_Start,
          (m_owner >= 0) && !m_started);
      chk($sformatf("rnd%0d.abusy", c), Arb_Busy, m_owner >= 0);
      chk($sformatf("rnd%0d.gid", c), Grant_Id, m_gid);
      chk($sformatf("rnd%0d.txd", c), Tx_Data, m_txd);
      chk($sformatf("rnd%0d.tmo", c), Timeout_Err, 1'b0);

      // UART stand-in: busy follows start after a short delay
      case (u_phase)
        0: begin
          if (Transmit_Start) begin
            u_cnt = $urandom_range(3);
            u_phase = 1;
          end else if (m_owner < 0 && $urandom_range(49) == 0) begin
            Tx_Busy = 1'b1;
            u_cnt = $urandom_range(3, 1);
            u_phase = 2;
          end
        end
        1: begin
          if (u_cnt == 0) begin
            Tx_Busy = 1'b1;
            u_cnt = $urandom_range(6, 1);
            u_phase = 2;
          end else u_cnt--;
        end
        default: begin
          if (u_cnt == 0) begin
            Tx_Busy = 1'b0;
            u_phase = 0;
          end else u_cnt--;
        end
      endcase

      // requesters: raise, renew after Ack, or occasionally withdraw
      for (int i = 0; i < N; i++) begin
        if (!Req[i]) begin
          if ($urandom_range(2) == 0) begin
            Req[i] = 1'b1;
            Req_Data[i*DB +: DB] = DB'($urandom);
          end
        end else if (ea[i]) begin
          if ($urandom_range(1) == 0) Req[i] = 1'b0;
          else Req_Data[i*DB +: DB] = DB'($urandom);
        end else if ($urandom_range(19) == 0) begin
          Req[i] = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
